axi_wr_slave: RTL and testbench

- AXI4-full write-channel slave (AW/W/B) sitting directly downstream of burst_axi's write DMA master port.
- Accepts one write burst at a time, converts the beats into a byte-strobed local memory write port, and returns one B response per burst.
- Replaces the behavioural AWREADY/WREADY/BVALID stubs in the channel bench with synthesizable RTL.

---
 rtl/axi_wr_slave_if.sv | 44 ++++
 rtl/axi_wr_slave.sv | 152 +++++++++++++++
 tb/tb_axi_wr_slave.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_slave_if.sv
// AXI4 write-channel bundle (AW/W/B) shared by the burst master and axi_wr_slave.
// The master modport drives the request side; the slave modport drives the ready/response side.
interface axi_wr_slave_if #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     S_AXI_AWID;
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [7:0]          S_AXI_AWLEN;
    logic [2:0]          S_AXI_AWSIZE;
    logic [1:0]          S_AXI_AWBURST;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;

    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WLAST;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;

    logic [ID_W-1:0]     S_AXI_BID;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY
    );

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY
    );
endinterface

// File: rtl/axi_wr_slave.sv
// Single-outstanding AXI4 write slave: turns each accepted burst into one registered,
// byte-strobed local memory write per beat and returns one B response per burst.
module axi_wr_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH     = 10
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    axi_wr_slave_if.slave                     s_axi,
    output logic                              mem_wr_en,
    output logic [MEM_ADDR_WIDTH-1:0]         mem_wr_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     mem_wr_data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   mem_wr_strb
);

    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int S      = (C_S_AXI_DATA_WIDTH == 64) ? 3 : 2;

    localparam logic [2:0] SIZE_FULL   = 3'(S);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DATA     = 2'd1;
    localparam logic [1:0] ST_RESP     = 2'd2;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]                    r_state;
    logic                          r_awready;
    logic                          r_wready;
    logic                          r_bvalid;
    logic [C_S_AXI_ID_WIDTH-1:0]   r_bid;
    logic [1:0]                    r_bresp;

    logic [C_S_AXI_ID_WIDTH-1:0]   r_id;
    logic [7:0]                    r_len;
    logic [1:0]                    r_burst;
    logic [MEM_ADDR_WIDTH-1:0]     r_addr;
    logic [7:0]                    r_beat;
    logic                          r_err;
    logic                          r_bad_cfg;

    logic                          r_mem_wr_en;
    logic [MEM_ADDR_WIDTH-1:0]     r_mem_wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_mem_wr_data;
    logic [STRB_W-1:0]             r_mem_wr_strb;

    logic                          w_aw_hs;
    logic                          w_w_hs;
    logic                          w_last_beat;
    logic                          w_wlast_err;
    logic                          w_bad_cfg;

    // Ready flags are only ever set in their own state, so the handshakes need no state qualifier.
    assign w_aw_hs     = s_axi.S_AXI_AWVALID & r_awready;
    assign w_w_hs      = s_axi.S_AXI_WVALID & r_wready;
    assign w_last_beat = (r_beat == r_len);
    assign w_wlast_err = s_axi.S_AXI_WLAST ^ w_last_beat;
    assign w_bad_cfg   = (s_axi.S_AXI_AWSIZE != SIZE_FULL) | s_axi.S_AXI_AWBURST[1];

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            r_state       <= ST_IDLE;
            r_awready     <= 1'b0;
            r_wready      <= 1'b0;
            r_bvalid      <= 1'b0;
            r_bid         <= '0;
            r_bresp       <= RESP_OKAY;
            r_id          <= '0;
            r_len         <= '0;
            r_burst       <= '0;
            r_addr        <= '0;
            r_beat        <= '0;
            r_err         <= 1'b0;
            r_bad_cfg     <= 1'b0;
            // NOTE: the write-port data/address registers are reset too, because every output must read 0 in reset.
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_addr <= '0;
            r_mem_wr_data <= '0;
            r_mem_wr_strb <= '0;
        end else begin
            // NOTE: non-blocking throughout; later assignments in this block override this default pulse clear.
            r_mem_wr_en <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_awready <= 1'b1;
                    if (w_aw_hs) begin
                        r_id      <= s_axi.S_AXI_AWID;
                        r_len     <= s_axi.S_AXI_AWLEN;
                        r_burst   <= s_axi.S_AXI_AWBURST;
                        r_addr    <= s_axi.S_AXI_AWADDR[MEM_ADDR_WIDTH+S-1:S];
                        r_beat    <= '0;
                        r_err     <= 1'b0;
                        r_bad_cfg <= w_bad_cfg;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_state   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_w_hs) begin
                        // Illegal size/burst bursts are drained but never reach memory.
                        r_mem_wr_en   <= ~r_bad_cfg;
                        r_mem_wr_addr <= r_addr;
                        r_mem_wr_data <= s_axi.S_AXI_WDATA;
                        r_mem_wr_strb <= s_axi.S_AXI_WSTRB;
                        if (r_burst == BURST_INCR) begin
                            r_addr <= r_addr + 1'b1;
                        end
                        r_beat <= r_beat + 8'd1;
                        r_err  <= r_err | w_wlast_err;
                        if (w_last_beat) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_id;
                            r_bresp  <= (r_err | r_bad_cfg | w_wlast_err) ? RESP_SLVERR : RESP_OKAY;
                            r_state  <= ST_RESP;
                        end
                    end
                end

                ST_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= RESP_OKAY;
                        r_awready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = r_awready;
    assign s_axi.S_AXI_WREADY  = r_wready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BID     = r_bid;
    assign s_axi.S_AXI_BRESP   = r_bresp;

    assign mem_wr_en   = r_mem_wr_en;
    assign mem_wr_addr = r_mem_wr_addr;
    assign mem_wr_data = r_mem_wr_data;
    assign mem_wr_strb = r_mem_wr_strb;

endmodule

// File: tb/tb_axi_wr_slave.sv
// Randomized bench for axi_wr_slave: a burst-level model predicts every memory write
// and every B response from the protocol rules; a monitor matches writes as they appear.
module tb_axi_wr_slave;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic clk;
    logic rst_n;
    logic        mem_wr_en;
    logic [9:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_strb;

    int n_checks;
    int n_errors;
    wr_t exp_q[$];
    wr_t mon_e;

    axi_wr_slave_if #(.ID_W(1), .ADDR_W(32), .DATA_W(32)) bus ();

    axi_wr_slave #(
        .C_S_AXI_ID_WIDTH(1),
        .C_S_AXI_ADDR_WIDTH(32),
        .C_S_AXI_DATA_WIDTH(32),
        .MEM_ADDR_WIDTH(10)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESETN(rst_n),
        .s_axi        (bus),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_strb  (mem_wr_strb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every memory write must match the oldest predicted write.
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", 1'b1, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", mem_wr_addr, mon_e.addr);
                check("wr_data", mem_wr_data, mon_e.data);
                check("wr_strb", mem_wr_strb, mon_e.strb);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle_bus();
        bus.S_AXI_AWID    = '0;
        bus.S_AXI_AWADDR  = '0;
        bus.S_AXI_AWLEN   = '0;
        bus.S_AXI_AWSIZE  = '0;
        bus.S_AXI_AWBURST = '0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = '0;
        bus.S_AXI_WSTRB   = '0;
        bus.S_AXI_WLAST   = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the AW handshake.
    task automatic send_aw(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        bus.S_AXI_AWID    = id;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWLEN   = len;
        bus.S_AXI_AWSIZE  = size;
        bus.S_AXI_AWBURST = burst;
        bus.S_AXI_AWVALID = 1'b1;
        while (bus.S_AXI_AWREADY !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("awready_wait", bus.S_AXI_AWREADY, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        check("awready_low_in_data", bus.S_AXI_AWREADY, 1'b0);
        check("wready_latency", bus.S_AXI_WREADY, 1'b1);
    endtask

    // Called at a negedge; returns at the negedge after the W handshake.
    task automatic send_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        bus.S_AXI_WDATA  = data;
        bus.S_AXI_WSTRB  = strb;
        bus.S_AXI_WLAST  = last;
        bus.S_AXI_WVALID = 1'b1;
        while (bus.S_AXI_WREADY !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wready_wait", bus.S_AXI_WREADY, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_WLAST  = 1'b0;
    endtask

    // gap: 0 none, 1 idle cycle before every beat after the first, 2 random idles.
    // bad_last: beat index whose WLAST is inverted, -1 for none.
    task automatic do_burst(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int bad_last,
                            input int gap, input int bready_delay, input bit directed);
        logic [9:0]  waddr   = addr[11:2];
        bit          bad_cfg = (size != 3'd2) || burst[1];
        bit          err     = bad_cfg || (bad_last >= 0 && bad_last <= int'(len));
        logic [31:0] d;
        logic [3:0]  s;

        send_aw(id, addr, len, size, burst);
        for (int b = 0; b <= int'(len); b++) begin
            if ((gap == 1 && b > 0) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                check("wready_during_gap", bus.S_AXI_WREADY, 1'b1);
                @(negedge clk);
            end
            d = directed ? 32'hA0 + 32'(b) : $urandom;
            s = directed ? 4'hF : (($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom));
            if (!bad_cfg) begin
                exp_q.push_back('{addr: waddr, data: d, strb: s});
            end
            if (burst == 2'b01) waddr = waddr + 10'd1;
            send_beat(d, s, (b == int'(len)) ^ (b == bad_last));
        end

        check("wready_after_last", bus.S_AXI_WREADY, 1'b0);
        for (int i = 0; i < bready_delay; i++) begin
            check("bvalid_hold", bus.S_AXI_BVALID, 1'b1);
            check("awready_in_resp", bus.S_AXI_AWREADY, 1'b0);
            @(negedge clk);
        end
        check("bvalid", bus.S_AXI_BVALID, 1'b1);
        check("bid", bus.S_AXI_BID, id);
        check("bresp", bus.S_AXI_BRESP, err ? 2'b10 : 2'b00);
        bus.S_AXI_BREADY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        check("bvalid_cleared", bus.S_AXI_BVALID, 1'b0);
        check("awready_after_b", bus.S_AXI_AWREADY, 1'b1);
        check("writes_outstanding", exp_q.size(), 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_bus();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_awready", bus.S_AXI_AWREADY, 1'b0);
        check("rst_wready", bus.S_AXI_WREADY, 1'b0);
        check("rst_bvalid", bus.S_AXI_BVALID, 1'b0);
        check("rst_bresp", bus.S_AXI_BRESP, 2'b00);
        check("rst_mem", {mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_strb}, '0);
        rst_n = 1'b1;
        check("awready_before_first_clk", bus.S_AXI_AWREADY, 1'b0);
        @(negedge clk);
        check("awready_after_reset", bus.S_AXI_AWREADY, 1'b1);

        // WVALID in IDLE is ignored.
        bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_WDATA  = 32'hDEAD_BEEF;
        bus.S_AXI_WSTRB  = 4'hF;
        repeat (2) begin
            check("wready_idle", bus.S_AXI_WREADY, 1'b0);
            @(negedge clk);
        end
        bus.S_AXI_WVALID = 1'b0;

        do_burst(1'b1, 32'h0000_0100, 8'd3, 3'd2, 2'b01, -1, 0, 0, 1'b1);
        do_burst(1'b0, 32'h0000_0200, 8'd0, 3'd2, 2'b01, -1, 0, 5, 1'b0);
        do_burst(1'b1, 32'h0000_0340, 8'd2, 3'd2, 2'b00, -1, 1, 0, 1'b0);
        do_burst(1'b0, 32'h0000_0080, 8'd3, 3'd2, 2'b01, 1, 0, 1, 1'b0);
        do_burst(1'b1, 32'h0000_0400, 8'd3, 3'd2, 2'b10, -1, 0, 0, 1'b0);
        do_burst(1'b0, 32'h0000_0500, 8'd2, 3'd1, 2'b01, -1, 0, 0, 1'b0);
        do_burst(1'b1, 32'h0000_0600, 8'd1, 3'd2, 2'b01, -1, 0, 0, 1'b0);
        do_burst(1'b0, 32'hABCD_0FF8, 8'd3, 3'd2, 2'b01, -1, 0, 0, 1'b0);

        // Reset after beat 1: no response, no further writes.
        send_aw(1'b1, 32'h0000_0010, 8'd3, 3'd2, 2'b01);
        exp_q.push_back('{addr: 10'h004, data: 32'h1111_0000, strb: 4'hF});
        send_beat(32'h1111_0000, 4'hF, 1'b0);
        exp_q.push_back('{addr: 10'h005, data: 32'h1111_0001, strb: 4'h3});
        send_beat(32'h1111_0001, 4'h3, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_bvalid", bus.S_AXI_BVALID, 1'b0);
        check("midrst_wready", bus.S_AXI_WREADY, 1'b0);
        rst_n = 1'b1;
        check("midrst_awready_release", bus.S_AXI_AWREADY, 1'b0);
        @(negedge clk);
        check("midrst_awready", bus.S_AXI_AWREADY, 1'b1);
        check("midrst_no_bvalid", bus.S_AXI_BVALID, 1'b0);
        check("midrst_writes", exp_q.size(), 0);

        for (int t = 0; t < 30; t++) begin
            logic [1:0] burst = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3))
                                                            : 2'($urandom_range(0, 1));
            logic [2:0] size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 1)) : 3'd2;
            int bad_last      = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1;
            do_burst(1'($urandom), $urandom, 8'($urandom_range(0, 15)), size, burst, bad_last,
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("final_no_writes", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
